// File: rtl/svm_dwell_time_gen.sv
// SVPWM dwell-time generator: phase/amplitude -> sector, LUT angles and T1/T2/T0 per carrier period.
// Optional minimum-pulse stage between LIMIT and OUT is enabled by defining SVM_MIN_PULSE_EN.
module svm_dwell_time_gen #(
  parameter int unsigned PERIOD      = 8000,
  parameter int unsigned PHASE_STEPS = 5760,
  parameter int unsigned MIN_PULSE   = 100,
  parameter int unsigned LUT_LAT     = 1,
  parameter int unsigned T_W         = 14
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           carrier_stb,
  input  logic [15:0]    amplitude,
  input  logic [15:0]    phase,
  output logic           lut_req,
  output logic [9:0]     lut_addr_t1,
  output logic [9:0]     lut_addr_t2,
  input  logic [15:0]    lut_sin_t1,
  input  logic [15:0]    lut_sin_t2,
  output logic [2:0]     sector,
  output logic           sub_half,
  output logic [T_W-1:0] T1,
  output logic [T_W-1:0] T2,
  output logic [T_W-1:0] T0,
  output logic           valid,
  output logic           busy,
  output logic           ovm
);

  localparam int unsigned SectorSteps = PHASE_STEPS / 6;
  localparam logic [1:0]  LutLastCnt  = 2'(LUT_LAT - 1);

  typedef enum logic [2:0] {StIdle, StSect, StLut, StMult, StLimit, StMinp, StOut} state_e;

`ifdef SVM_MIN_PULSE_EN
  localparam state_e LoadSt = StMinp;
`else
  localparam state_e LoadSt = StLimit;
`endif

  state_e         state_q, state_d;
  logic           armed_q;
  logic [15:0]    amp_q, phase_q;
  logic [1:0]     cnt_q;
  logic           lut_req_q;
  logic [9:0]     addr_t1_q, addr_t2_q;
  logic [2:0]     sect_q;
  logic           half_q;
  logic [16:0]    t1b_q, t2b_q;
  logic [T_W-1:0] t1_q, t2_q, t0_q;
  logic [2:0]     sector_q;
  logic           sub_half_q, ovm_q;

  // FSM next state; a low enable always returns to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (carrier_stb && armed_q) state_d = StSect;
      StSect:  state_d = StLut;
      StLut:   if (cnt_q == LutLastCnt) state_d = StMult;
      StMult:  state_d = StLimit;
      StLimit: state_d = (LoadSt == StMinp) ? StMinp : StOut;
      StMinp:  state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (!enable) state_d = StIdle;
  end

  // Sector from a compare chain against multiples of SectorSteps
  logic [2:0]  sect_d;
  logic [15:0] base;
  logic [9:0]  theta;
  always_comb begin
    sect_d = 3'd1;
    base   = '0;
    for (int k = 1; k < 6; k++) begin
      if (phase_q >= 16'(k * SectorSteps)) begin
        sect_d = 3'(k + 1);
        base   = 16'(k * SectorSteps);
      end
    end
    theta = 10'(phase_q - base);
  end

  logic [31:0] prod1, prod2;
  assign prod1 = 32'(amp_q) * 32'(lut_sin_t1);
  assign prod2 = 32'(amp_q) * 32'(lut_sin_t2);

  // Over-modulation limiting: excess d is split between T1 and T2
  logic [17:0]    sum, d_u, dh_u, dl_u;
  logic           d_pos;
  logic [T_W-1:0] lim_t1, lim_t2, lim_t0;
  always_comb begin
    sum   = {1'b0, t1b_q} + {1'b0, t2b_q};
    d_u   = sum - 18'(PERIOD);
    dh_u  = {1'b0, d_u[17:1]};
    dl_u  = d_u - dh_u;
    d_pos = !d_u[17] && (d_u != '0);
    if (d_pos) begin
      lim_t1 = T_W'({1'b0, t1b_q} - dl_u);
      lim_t2 = T_W'({1'b0, t2b_q} - dh_u);
      lim_t0 = '0;
    end else begin
      lim_t1 = T_W'(t1b_q);
      lim_t2 = T_W'(t2b_q);
      lim_t0 = T_W'(18'(PERIOD) - sum);
    end
  end

  logic [T_W-1:0] fin_t1, fin_t2, fin_t0;
  logic           fin_ovm;

`ifdef SVM_MIN_PULSE_EN
  localparam logic [T_W-1:0] MinP = T_W'(MIN_PULSE);
  logic [T_W-1:0] lt1_q, lt2_q, lt0_q;
  logic           lovm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lt1_q  <= '0;
      lt2_q  <= '0;
      lt0_q  <= '0;
      lovm_q <= 1'b0;
    end else if (state_q == StLimit) begin
      lt1_q  <= lim_t1;
      lt2_q  <= lim_t2;
      lt0_q  <= lim_t0;
      lovm_q <= d_pos;
    end
  end

  // Unrealisable dwells are folded into neighbours, preserving the period
  always_comb begin
    fin_t1  = lt1_q;
    fin_t2  = lt2_q;
    fin_t0  = lt0_q;
    fin_ovm = lovm_q;
    if (lt1_q < MinP && lt2_q < MinP) begin
      fin_t1 = '0;
      fin_t2 = '0;
      fin_t0 = T_W'(PERIOD);
    end else if (lt0_q < MinP) begin
      fin_t1 = lt1_q + (lt0_q >> 1);
      fin_t2 = lt2_q + (lt0_q - (lt0_q >> 1));
      fin_t0 = '0;
    end else if (lt1_q < MinP) begin
      fin_t2 = lt2_q + (lt1_q >> 1);
      fin_t0 = lt0_q + (lt1_q - (lt1_q >> 1));
      fin_t1 = '0;
    end else if (lt2_q < MinP) begin
      fin_t1 = lt1_q + (lt2_q >> 1);
      fin_t0 = lt0_q + (lt2_q - (lt2_q >> 1));
      fin_t2 = '0;
    end
  end
`else
  always_comb begin
    fin_t1  = lim_t1;
    fin_t2  = lim_t2;
    fin_t0  = lim_t0;
    fin_ovm = d_pos;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      armed_q <= 1'b0;
      amp_q   <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == StLut) ? cnt_q + 2'd1 : '0;
      if (!enable) begin
        armed_q <= 1'b0;
      end else if (state_q == StIdle && carrier_stb) begin
        armed_q <= 1'b1;
        if (amplitude <= 16'(PERIOD))    amp_q   <= amplitude;
        if (phase < 16'(PHASE_STEPS))    phase_q <= phase;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lut_req_q  <= 1'b0;
      addr_t1_q  <= '0;
      addr_t2_q  <= '0;
      sect_q     <= '0;
      half_q     <= 1'b0;
      t1b_q      <= '0;
      t2b_q      <= '0;
      t1_q       <= '0;
      t2_q       <= '0;
      t0_q       <= '0;
      sector_q   <= '0;
      sub_half_q <= 1'b0;
      ovm_q      <= 1'b0;
    end else begin
      lut_req_q <= enable && (state_q == StSect);
      if (state_q == StSect) begin
        addr_t1_q <= 10'(SectorSteps) - theta;
        addr_t2_q <= theta;
        sect_q    <= sect_d;
        half_q    <= theta >= 10'(SectorSteps / 2);
      end
      if (state_q == StMult) begin
        t1b_q <= 17'(prod1 >> 15);
        t2b_q <= 17'(prod2 >> 15);
      end
      if (!enable) begin
        t1_q       <= '0;
        t2_q       <= '0;
        t0_q       <= '0;
        sector_q   <= '0;
        sub_half_q <= 1'b0;
        ovm_q      <= 1'b0;
      end else if (state_q == LoadSt) begin
        t1_q       <= fin_t1;
        t2_q       <= fin_t2;
        t0_q       <= fin_t0;
        sector_q   <= sect_q;
        sub_half_q <= half_q;
        ovm_q      <= fin_ovm;
      end
    end
  end

  assign lut_req     = lut_req_q;
  assign lut_addr_t1 = addr_t1_q;
  assign lut_addr_t2 = addr_t2_q;
  assign sector      = sector_q;
  assign sub_half    = sub_half_q;
  assign T1          = t1_q;
  assign T2          = t2_q;
  assign T0          = t0_q;
  assign ovm         = ovm_q;
  assign valid       = (state_q == StOut);
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_svm_dwell_time_gen.sv
// Directed bench for svm_dwell_time_gen with a behavioural fixed-latency sine LUT.
module tb_svm_dwell_time_gen;

  localparam int LUT_LAT = 1;
`ifdef SVM_MIN_PULSE_EN
  localparam int ExpLat = 5 + LUT_LAT;
`else
  localparam int ExpLat = 4 + LUT_LAT;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        carrier_stb = 1'b0;
  logic [15:0] amplitude = '0;
  logic [15:0] phase = '0;
  logic        lut_req;
  logic [9:0]  lut_addr_t1, lut_addr_t2;
  logic [15:0] lut_sin_t1, lut_sin_t2;
  logic [2:0]  sector;
  logic        sub_half;
  logic [13:0] T1, T2, T0;
  logic        valid, busy, ovm;

  logic [15:0] sin1_val = '0;
  logic [15:0] sin2_val = '0;
  logic [3:0]  lut_pipe = '0;

  int checks = 0;
  int failures = 0;

  svm_dwell_time_gen #(
    .PERIOD(8000), .PHASE_STEPS(5760), .MIN_PULSE(100), .LUT_LAT(LUT_LAT), .T_W(14)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .carrier_stb(carrier_stb),
    .amplitude(amplitude), .phase(phase), .lut_req(lut_req),
    .lut_addr_t1(lut_addr_t1), .lut_addr_t2(lut_addr_t2),
    .lut_sin_t1(lut_sin_t1), .lut_sin_t2(lut_sin_t2),
    .sector(sector), .sub_half(sub_half), .T1(T1), .T2(T2), .T0(T0),
    .valid(valid), .busy(busy), .ovm(ovm)
  );

  always #5 clk = ~clk;

  // LUT data is only meaningful LUT_LAT cycles after the request; zero otherwise
  always @(posedge clk) lut_pipe <= {lut_pipe[2:0], lut_req};
  assign lut_sin_t1 = lut_pipe[LUT_LAT-1] ? sin1_val : 16'h0000;
  assign lut_sin_t2 = lut_pipe[LUT_LAT-1] ? sin2_val : 16'h0000;

  // Strobe once and return the cycle index of valid (-1 if none within the bound)
  task automatic fire(output int lat);
    lat = -1;
    @(negedge clk);
    carrier_stb = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      carrier_stb = 1'b0;
      if (valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic setup(input logic [15:0] a, input logic [15:0] p,
                       input logic [15:0] s1, input logic [15:0] s2);
    amplitude = a;
    phase     = p;
    sin1_val  = s1;
    sin2_val  = s2;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({T1, T2, T0} !== 42'd0) begin
      failures++;
      $display("FAIL reset_t got=%0d/%0d/%0d want=0/0/0", T1, T2, T0);
    end
    checks++;
    if ({sector, sub_half, ovm, valid, busy, lut_req} !== 8'd0) begin
      failures++;
      $display("FAIL reset_ctrl got sector=%0d valid=%0b busy=%0b ovm=%0b want all 0",
               sector, valid, busy, ovm);
    end
  endtask

  task automatic test_arm_zero_amp;
    int lat;
    setup(16'd0, 16'd0, 16'd16384, 16'd16384);
    fire(lat);
    checks++;
    if (lat != -1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL arm_only got lat=%0d busy=%0b want lat=-1 busy=0", lat, busy);
    end
    fire(lat);
    checks++;
    if (lat != ExpLat) begin
      failures++;
      $display("FAIL zero_latency got=%0d want=%0d", lat, ExpLat);
    end
    checks++;
    if (T1 !== 14'd0 || T2 !== 14'd0 || T0 !== 14'd8000 || sector !== 3'd1 || ovm !== 1'b0) begin
      failures++;
      $display("FAIL zero_amp got=%0d/%0d/%0d s=%0d ovm=%0b want=0/0/8000 s=1 ovm=0",
               T1, T2, T0, sector, ovm);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_at_valid got=%0b want=1", busy);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || T0 !== 14'd8000) begin
      failures++;
      $display("FAIL after_valid got valid=%0b busy=%0b T0=%0d want 0/0/8000", valid, busy, T0);
    end
  endtask

  task automatic test_half_scale;
    int lat;
    setup(16'd8000, 16'd480, 16'd16384, 16'd16384);
    fire(lat);
    checks++;
    if (lat != ExpLat || lut_addr_t1 !== 10'd480 || lut_addr_t2 !== 10'd480) begin
      failures++;
      $display("FAIL half_addr got lat=%0d a1=%0d a2=%0d want lat=%0d a1=480 a2=480",
               lat, lut_addr_t1, lut_addr_t2, ExpLat);
    end
    checks++;
    if (T1 !== 14'd4000 || T2 !== 14'd4000 || T0 !== 14'd0) begin
      failures++;
      $display("FAIL half_t got=%0d/%0d/%0d want=4000/4000/0", T1, T2, T0);
    end
    checks++;
    if (sector !== 3'd1 || sub_half !== 1'b1 || ovm !== 1'b0) begin
      failures++;
      $display("FAIL half_sect got s=%0d h=%0b ovm=%0b want s=1 h=1 ovm=0", sector, sub_half, ovm);
    end
  endtask

  task automatic test_overmod;
    int lat;
    setup(16'd8000, 16'd480, 16'd20000, 16'd20000);
    fire(lat);
    checks++;
    if (lat != ExpLat || T1 !== 14'd4000 || T2 !== 14'd4000 || T0 !== 14'd0 || ovm !== 1'b1) begin
      failures++;
      $display("FAIL overmod got lat=%0d %0d/%0d/%0d ovm=%0b want %0d 4000/4000/0 ovm=1",
               lat, T1, T2, T0, ovm, ExpLat);
    end
  endtask

  task automatic test_sector6;
    int lat;
    setup(16'd8000, 16'd5000, 16'd16384, 16'd16384);
    fire(lat);
    checks++;
    if (lat != ExpLat || sector !== 3'd6 || sub_half !== 1'b0) begin
      failures++;
      $display("FAIL sect6 got lat=%0d s=%0d h=%0b want %0d s=6 h=0", lat, sector, sub_half, ExpLat);
    end
    checks++;
    if (lut_addr_t1 !== 10'd760 || lut_addr_t2 !== 10'd200) begin
      failures++;
      $display("FAIL sect6_addr got a1=%0d a2=%0d want a1=760 a2=200", lut_addr_t1, lut_addr_t2);
    end
    phase = 16'd6000;
    fire(lat);
    checks++;
    if (lat != ExpLat || sector !== 3'd6 || lut_addr_t1 !== 10'd760 || lut_addr_t2 !== 10'd200) begin
      failures++;
      $display("FAIL phase_reject got lat=%0d s=%0d a1=%0d a2=%0d want s=6 a1=760 a2=200",
               lat, sector, lut_addr_t1, lut_addr_t2);
    end
  endtask

  task automatic test_small_t2;
    int lat;
    setup(16'd8000, 16'd480, 16'd16384, 16'd800);
    fire(lat);
    checks++;
    if (lat != ExpLat || T1 !== 14'd4000 || T2 !== 14'd195 || T0 !== 14'd3805 || ovm !== 1'b0) begin
      failures++;
      $display("FAIL small_t2 got lat=%0d %0d/%0d/%0d want 4000/195/3805", lat, T1, T2, T0);
    end
  endtask

  task automatic test_min_t0;
    int lat;
    logic [13:0] e1, e2, e0;
`ifdef SVM_MIN_PULSE_EN
    e1 = 14'd4047; e2 = 14'd3953; e0 = 14'd0;
`else
    e1 = 14'd4000; e2 = 14'd3906; e0 = 14'd94;
`endif
    setup(16'd8000, 16'd480, 16'd16384, 16'd16000);
    fire(lat);
    checks++;
    if (lat != ExpLat || T1 !== e1 || T2 !== e2 || T0 !== e0) begin
      failures++;
      $display("FAIL min_t0 got lat=%0d %0d/%0d/%0d want %0d/%0d/%0d", lat, T1, T2, T0, e1, e2, e0);
    end
    checks++;
    if (14'(T1 + T2 + T0) !== 14'd8000) begin
      failures++;
      $display("FAIL period_sum got=%0d want=8000", T1 + T2 + T0);
    end
  endtask

  task automatic test_enable_drop;
    int lat;
    int seen;
    setup(16'd8000, 16'd480, 16'd16384, 16'd16384);
    @(negedge clk);
    carrier_stb = 1'b1;
    @(negedge clk);
    carrier_stb = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({T1, T2, T0} !== 42'd0 || sector !== 3'd0 || valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL disable got %0d/%0d/%0d s=%0d v=%0b b=%0b want all 0",
               T1, T2, T0, sector, valid, busy);
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abandon got valid_count=%0d want=0", seen);
    end
    enable = 1'b1;
    fire(lat);
    checks++;
    if (lat != -1) begin
      failures++;
      $display("FAIL rearm got lat=%0d want=-1", lat);
    end
    fire(lat);
    checks++;
    if (lat != ExpLat || T1 !== 14'd4000 || T2 !== 14'd4000 || sector !== 3'd1) begin
      failures++;
      $display("FAIL reenable got lat=%0d %0d/%0d s=%0d want %0d 4000/4000 s=1",
               lat, T1, T2, sector, ExpLat);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int seen;
    setup(16'd8000, 16'd480, 16'd16384, 16'd16384);
    lat = -1;
    @(negedge clk);
    carrier_stb = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      carrier_stb = (n == 2);
      if (n == 2) amplitude = 16'd0;
      if (valid) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != ExpLat || T1 !== 14'd4000 || T2 !== 14'd4000) begin
      failures++;
      $display("FAIL busy_strobe got lat=%0d %0d/%0d want %0d 4000/4000", lat, T1, T2, ExpLat);
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL not_queued got valid_count=%0d want=0", seen);
    end
    amplitude = 16'd9000;
    fire(lat);
    checks++;
    if (lat != ExpLat || T1 !== 14'd4000 || T2 !== 14'd4000 || T0 !== 14'd0) begin
      failures++;
      $display("FAIL amp_hold got lat=%0d %0d/%0d/%0d want 4000/4000/0", lat, T1, T2, T0);
    end
  endtask

  initial begin
    test_reset();
    test_arm_zero_amp();
    test_half_scale();
    test_overmod();
    test_sector6();
    test_small_t2();
    test_min_t0();
    test_enable_drop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
